// File: rtl/rf_pkg.sv
// Shared constants and types for the register file.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  typedef struct packed {
    logic overflow;
    logic cout;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address decode, r0 forced to zero, and optional
// write-through bypass when RF_BYPASS_EN is defined.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                                   i_rst_n,
  input  logic [ADDR_W-1:0]                      i_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]     i_regs,
  input  logic                                   i_we,
  input  logic [ADDR_W-1:0]                      i_waddr,
  input  logic [DATA_W-1:0]                      i_wdata,
  output logic [DATA_W-1:0]                      o_data
);

`ifdef RF_BYPASS_EN
  logic w_hit;
  assign w_hit = i_we && (i_waddr == i_addr);
`else
  logic w_unused;
  assign w_unused = ^{i_we, i_waddr, i_wdata};
`endif

  always_comb begin
    o_data = i_regs[i_addr];
`ifdef RF_BYPASS_EN
    if (w_hit) o_data = i_wdata;
`endif
    // r0 and reset both win over the bypass so a write held during reset never leaks out
    if (!i_rst_n || (i_addr == '0)) o_data = '0;
  end

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with r0 hardwired to zero and a registered
// ALU flag capture. Define RF_BYPASS_EN for same-cycle write-through reads.
module reg_file
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RSaddr,
  input  logic [ADDR_W-1:0] RTaddr,
  input  logic [ADDR_W-1:0] RDaddr,
  input  logic [DATA_W-1:0] RDdata,
  input  logic              RegWrite,
  input  logic              flag_we,
  input  logic              zero_i,
  input  logic              cout_i,
  input  logic              overflow_i,
  output logic [DATA_W-1:0] RSdata,
  output logic [DATA_W-1:0] RTdata,
  output logic [2:0]        flags_o
);

  localparam int N_REGS = 2 ** ADDR_W;

  logic [N_REGS-1:0][DATA_W-1:0] r_regs;
  alu_flags_t                    r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (RegWrite && (RDaddr != '0)) begin
      r_regs[RDaddr] <= RDdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (flag_we) begin
      r_flags <= '{overflow: overflow_i, cout: cout_i, zero: zero_i};
    end
  end

  assign flags_o = r_flags;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_rs (
    .i_rst_n (rst_n),
    .i_addr  (RSaddr),
    .i_regs  (r_regs),
    .i_we    (RegWrite),
    .i_waddr (RDaddr),
    .i_wdata (RDdata),
    .o_data  (RSdata)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_rt (
    .i_rst_n (rst_n),
    .i_addr  (RTaddr),
    .i_regs  (r_regs),
    .i_we    (RegWrite),
    .i_waddr (RDaddr),
    .i_wdata (RDdata),
    .o_data  (RTdata)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expected values are hand-computed.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  RSaddr, RTaddr, RDaddr;
  logic [31:0] RDdata;
  logic        RegWrite, flag_we, zero_i, cout_i, overflow_i;
  logic [31:0] RSdata, RTdata;
  logic [2:0]  flags_o;

  int n_cmp = 0;
  int n_err = 0;

  reg_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RSaddr     (RSaddr),
    .RTaddr     (RTaddr),
    .RDaddr     (RDaddr),
    .RDdata     (RDdata),
    .RegWrite   (RegWrite),
    .flag_we    (flag_we),
    .zero_i     (zero_i),
    .cout_i     (cout_i),
    .overflow_i (overflow_i),
    .RSdata     (RSdata),
    .RTdata     (RTdata),
    .flags_o    (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_same;
`ifdef RF_BYPASS_EN
    exp_same = 32'hA5A5_A5A5;
`else
    exp_same = 32'h0000_0000;
`endif

    rst_n = 1'b1; RSaddr = '0; RTaddr = '0; RDaddr = '0; RDdata = '0;
    RegWrite = 1'b0; flag_we = 1'b0; zero_i = 1'b0; cout_i = 1'b0; overflow_i = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_rs", RSdata, 32'h0);
    check("reset_rt", RTdata, 32'h0);
    check("reset_flags", {29'h0, flags_o}, 32'h0);

    // release before the first edge and write immediately
    rst_n = 1'b1;
    RegWrite = 1'b1; RDaddr = 5'd5; RDdata = 32'hDEAD_BEEF; RSaddr = 5'd5;
    flag_we = 1'b1; overflow_i = 1'b1; cout_i = 1'b1; zero_i = 1'b0;
    tick();
    check("first_write_r5", RSdata, 32'hDEAD_BEEF);
    check("first_flags", {29'h0, flags_o}, 32'h6);
    RegWrite = 1'b0; flag_we = 1'b0;

    // asynchronous reset, no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_r5", RSdata, 32'h0);
    check("async_rst_flags", {29'h0, flags_o}, 32'h0);

    // write presented during reset, including a matching read address
    RegWrite = 1'b1; RDaddr = 5'd9; RDdata = 32'h1; RSaddr = 5'd9; RTaddr = 5'd9;
    #1;
    check("rst_read_rs", RSdata, 32'h0);
    check("rst_read_rt", RTdata, 32'h0);
    tick();
    check("rst_write_r9", RSdata, 32'h0);
    RegWrite = 1'b0; rst_n = 1'b1;
    tick();
    check("after_rst_r9", RSdata, 32'h0);
    RSaddr = 5'd5;
    #1;
    check("after_rst_r5", RSdata, 32'h0);

    // r0 write is discarded
    RegWrite = 1'b1; RDaddr = 5'd0; RDdata = 32'hFFFF_FFFF;
    tick();
    RegWrite = 1'b0; RSaddr = 5'd0; RTaddr = 5'd0;
    #1;
    check("r0_rs", RSdata, 32'h0);
    check("r0_rt", RTdata, 32'h0);

    // basic write, both ports on the same register
    RegWrite = 1'b1; RDaddr = 5'd7; RDdata = 32'h1234_5678;
    tick();
    RegWrite = 1'b0; RSaddr = 5'd7; RTaddr = 5'd7;
    #1;
    check("r7_rs", RSdata, 32'h1234_5678);
    check("r7_rt", RTdata, 32'h1234_5678);
    RSaddr = 5'd1; RTaddr = 5'd31;
    #1;
    check("r1_untouched", RSdata, 32'h0);
    check("r31_untouched", RTdata, 32'h0);

    // same-cycle read of the register being written
    RegWrite = 1'b1; RDaddr = 5'd3; RDdata = 32'hA5A5_A5A5; RSaddr = 5'd3; RTaddr = 5'd3;
    #1;
    check("same_cycle_rs", RSdata, exp_same);
    check("same_cycle_rt", RTdata, exp_same);
    tick();
    RegWrite = 1'b0;
    #1;
    check("r3_after_edge", RSdata, 32'hA5A5_A5A5);

    // simultaneous register write and flag capture
    RegWrite = 1'b1; RDaddr = 5'd12; RDdata = 32'hCAFE_F00D;
    flag_we = 1'b1; zero_i = 1'b1; cout_i = 1'b0; overflow_i = 1'b1;
    tick();
    RegWrite = 1'b0; flag_we = 1'b0; RSaddr = 5'd12; RTaddr = 5'd7;
    #1;
    check("flags_101", {29'h0, flags_o}, 32'h5);
    check("r12_with_flags", RSdata, 32'hCAFE_F00D);
    check("r7_other_port", RTdata, 32'h1234_5678);
    zero_i = 1'b0; cout_i = 1'b1; overflow_i = 1'b0;
    tick();
    tick();
    check("flags_hold", {29'h0, flags_o}, 32'h5);

    // hold with RegWrite low while write data/address toggle
    RDaddr = 5'd7; RDdata = 32'h0BAD_0BAD; RSaddr = 5'd7;
    tick();
    RDdata = 32'hFFFF_0000;
    tick();
    check("r7_hold", RSdata, 32'h1234_5678);

    // top address
    RegWrite = 1'b1; RDaddr = 5'd31; RDdata = 32'h8000_0001;
    tick();
    RegWrite = 1'b0; RTaddr = 5'd31;
    #1;
    check("r31_write", RTdata, 32'h8000_0001);
    check("r7_after_r31", RSdata, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and operand width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width, giving 2**ADDR_W registers.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port RSaddr, input, ADDR_W, meaning read port A address (ALU src1).
REQ-006 The block SHALL have port RTaddr, input, ADDR_W, meaning read port B address (ALU src2).
REQ-007 The block SHALL have port RDaddr, input, ADDR_W, meaning write address.
REQ-008 The block SHALL have port RDdata, input, DATA_W, meaning write data (ALU result).
REQ-009 The block SHALL have port RegWrite, input, 1, meaning write enable.
REQ-010 The block SHALL have port flag_we, input, 1, meaning capture ALU flags this cycle.
REQ-011 The block SHALL have ports zero_i, cout_i and overflow_i, each input, 1, meaning the ALU status flags.
REQ-012 The block SHALL have port RSdata, output, DATA_W, meaning read port A data.
REQ-013 The block SHALL have port RTdata, output, DATA_W, meaning read port B data.
REQ-014 The block SHALL have port flags_o, output, 3, meaning registered {overflow, cout, zero}.

Function
REQ-015 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-016 A write SHALL occur on the rising clk edge when RegWrite=1 and rst_n=1, storing RDdata at RDaddr.
REQ-017 Register 0 SHALL read as 0 at all times, and writes to address 0 SHALL be discarded.
REQ-018 When both read ports address the same register, both SHALL return identical data.
REQ-019 When RegWrite=0, storage SHALL hold unchanged indefinitely.
REQ-020 flags_o SHALL load {overflow_i, cout_i, zero_i} on the rising edge when flag_we=1, and otherwise hold its value.
REQ-021 Simultaneous RegWrite and flag_we SHALL both take effect in the same cycle, with no ordering dependency.
REQ-022 The read-during-write result at a matching address is defined by REQ-027/REQ-028.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately, independent of clk, clear all registers and flags_o to 0.
REQ-024 While rst_n=0, RSdata and RTdata SHALL read 0 and writes SHALL be ignored.
REQ-025 A reset asserted mid-sequence SHALL discard any write presented in that cycle.
REQ-026 The first write after rst_n deasserts SHALL take effect on the first rising edge with rst_n=1.

Configuration
REQ-027 With macro RF_BYPASS_EN defined, a read whose address equals RDaddr (non-zero) while RegWrite=1 SHALL return RDdata in the same cycle (write-through).
REQ-028 Without RF_BYPASS_EN, such a read SHALL return the old stored value, with the new value visible from the cycle after the edge.

Structure
REQ-029 Package rf_pkg SHALL hold the DATA_W/ADDR_W defaults, the NUM_REGS constant, and a packed alu_flags_t typedef {overflow, cout, zero}.
REQ-030 One sub-module, rf_read_port, SHALL implement the address decode, the r0 force-to-zero and the optional bypass mux, and SHALL be instantiated twice.

Verification
REQ-031 Reset scenario: set rst_n=0 after writing r5=0xDEADBEEF -> RSaddr=5 reads 0x00000000 and flags_o=3'b000 immediately, without a clock edge.
REQ-032 r0 write scenario: write r0=0xFFFFFFFF -> next cycle RSaddr=0 reads 0x00000000.
REQ-033 Basic write scenario: write r7=0x12345678, then read RSaddr=7 and RTaddr=7 -> both read 0x12345678; other registers remain 0.
REQ-034 Same-cycle read scenario: RegWrite=1, RDaddr=3, RDdata=0xA5A5A5A5 and RSaddr=3 in the same cycle -> RSdata=0xA5A5A5A5 with RF_BYPASS_EN defined, and the old value 0x00000000 without it.
REQ-035 Flag capture scenario: flag_we=1 with zero_i=1, cout_i=0, overflow_i=1 -> flags_o=3'b101 next cycle; then flag_we=0 with the inputs changed -> flags_o stays 3'b101.
REQ-036 Write-during-reset scenario: RegWrite=1, RDaddr=9, RDdata=0x1 with rst_n=0 -> after rst_n=1, r9 reads 0x00000000.
